// File: rtl/rdcl_sub32_pipe.sv
// Pipelined recursive-doubling borrow-lookahead subtractor: diff = in1 - in2 - bin, bout, signed ovf.
// Latency LEVELS+2 cycles; one global advance signal freezes every stage while the output is stalled.
module rdcl_sub32_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int LEVELS = $clog2(WIDTH);

   // Carry-state vectors are WIDTH+1 wide: index 0 is the seed (carry-in), index i+1 is operand bit i.
   logic [WIDTH:0]   g_q    [0:LEVELS];
   logic [WIDTH:0]   p_q    [0:LEVELS];
   logic [WIDTH:0]   g_d    [1:LEVELS];
   logic [WIDTH:0]   p_d    [1:LEVELS];
   logic [WIDTH-1:0] pv_q   [0:LEVELS];
   logic             vld_q  [0:LEVELS];
   logic             msb1_q [0:LEVELS];
   logic             msb2_q [0:LEVELS];

   logic             adv;
   logic [WIDTH-1:0] g0_d;
   logic [WIDTH-1:0] p0_d;
   logic             cout;
   logic [WIDTH-1:0] diff_d;
   logic             bout_d;
   logic             ovf_d;
   logic             out_vld_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;

   assign adv      = ~(out_vld_q & ~out_ready);
   assign in_ready = adv;

   assign g0_d = in1 & ~in2;
   assign p0_d = in1 ^ ~in2;

   always_comb begin
      for (int k = 1; k <= LEVELS; k++) begin
         g_d[k] = g_q[k-1];
         p_d[k] = p_q[k-1];
         for (int j = (1 << (k-1)); j <= WIDTH; j++) begin
            g_d[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j - (1 << (k-1))]);
            p_d[k][j] = p_q[k-1][j] & p_q[k-1][j - (1 << (k-1))];
         end
      end
   end

   // After the last level the top entry spans bits 0..WIDTH-1 only; fold in the seed for carry-out.
   assign cout   = g_q[LEVELS][WIDTH] | (p_q[LEVELS][WIDTH] & g_q[LEVELS][0]);
   assign diff_d = pv_q[LEVELS] ^ g_q[LEVELS][WIDTH-1:0];
   assign bout_d = ~cout;
   assign ovf_d  = (msb1_q[LEVELS] ^ msb2_q[LEVELS]) & (diff_d[WIDTH-1] ^ msb1_q[LEVELS]);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LEVELS; k++) begin
            vld_q[k]  <= 1'b0;
            g_q[k]    <= '0;
            p_q[k]    <= '0;
            pv_q[k]   <= '0;
            msb1_q[k] <= 1'b0;
            msb2_q[k] <= 1'b0;
         end
         out_vld_q <= 1'b0;
         diff_q    <= '0;
         bout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (adv) begin
         vld_q[0]  <= in_valid;
         g_q[0]    <= {g0_d, ~bin};
         p_q[0]    <= {p0_d, 1'b0};
         pv_q[0]   <= p0_d;
         msb1_q[0] <= in1[WIDTH-1];
         msb2_q[0] <= in2[WIDTH-1];
         for (int k = 1; k <= LEVELS; k++) begin
            vld_q[k]  <= vld_q[k-1];
            g_q[k]    <= g_d[k];
            p_q[k]    <= p_d[k];
            pv_q[k]   <= pv_q[k-1];
            msb1_q[k] <= msb1_q[k-1];
            msb2_q[k] <= msb2_q[k-1];
         end
         out_vld_q <= vld_q[LEVELS];
         diff_q    <= diff_d;
         bout_q    <= bout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_valid = out_vld_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rdcl_sub32_pipe.sv
// Directed and randomised checks of rdcl_sub32_pipe: latency, arithmetic corners, stall, reset flush.
module tb_rdcl_sub32_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   always #5 clk = ~clk;

   rdcl_sub32_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        b;
      logic        o;
   } res_t;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_got    = 0;
   res_t exp_q [$];
   res_t e_mon;
   logic hold_prev = 1'b0;
   logic [34:0] prev_out;

   logic [31:0] ta [8] = '{32'd3, 32'd13, 32'd113, 32'd12, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h12345678};
   logic [31:0] tb [8] = '{32'd12, 32'd12, 32'd121, 32'd12, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
   logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [31:0] td [8] = '{32'hFFFFFFF7, 32'h00000001, 32'hFFFFFFF8, 32'hFFFFFFFF,
                           32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
   logic        tbo [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
      logic [32:0] r;
      res_t        m;
      r   = {1'b0, a} - {1'b0, b} - {32'd0, c};
      m.d = r[31:0];
      m.b = r[32];
      m.o = (a[31] != b[31]) && (r[31] != a[31]);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] b, input logic c);
      in_valid = 1'b1;
      in1 = a;
      in2 = b;
      bin = c;
      tick();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("wait_out_valid", out_valid, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Scoreboard and output-hold monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev)
            chk("hold_stable", {out_valid, bout, ovf, diff}, prev_out);
         if (out_valid && out_ready) begin
            chk("sb_expected_present", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e_mon = exp_q.pop_front();
               chk("sb_diff", diff, e_mon.d);
               chk("sb_bout", bout, e_mon.b);
               chk("sb_ovf", ovf, e_mon.o);
               n_got++;
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in1, in2, bin));
         hold_prev = out_valid & ~out_ready;
         prev_out  = {out_valid, bout, ovf, diff};
      end
   end

   initial begin
      int   n;
      int   lat;
      int   i;
      int   lowc;
      int   got0;
      logic started;
      logic acc;
      logic [31:0] held;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; bin = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // single op, latency
      in_valid = 1'b1; in1 = 32'd33; in2 = 32'd12; bin = 1'b0;
      tick();
      in_valid = 1'b0;
      wait_valid(n);
      lat = n + 1;
      chk("t1_latency", lat, 7);
      chk("t1_diff", diff, 32'd21);
      chk("t1_bout", bout, 0);
      chk("t1_ovf", ovf, 0);
      tick();
      chk("t1_valid_drop", out_valid, 0);

      // back-to-back groups of four, incl. boundary operands
      for (int g = 0; g < 2; g++) begin
         for (int j = 0; j < 4; j++) put(ta[g*4+j], tb[g*4+j], tc[g*4+j]);
         in_valid = 1'b0;
         wait_valid(n);
         for (int j = 0; j < 4; j++) begin
            chk("t2_valid", out_valid, 1);
            chk("t2_diff", diff, td[g*4+j]);
            chk("t2_bout", bout, tbo[g*4+j]);
            chk("t2_ovf", ovf, 0);
            tick();
         end
         chk("t2_valid_drop", out_valid, 0);
      end

      // signed overflow
      put(32'h80000000, 32'd1, 1'b0);
      in_valid = 1'b0;
      wait_valid(n);
      chk("t3a_diff", diff, 32'h7FFFFFFF);
      chk("t3a_ovf", ovf, 1);
      chk("t3a_bout", bout, 0);
      tick();
      put(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
      in_valid = 1'b0;
      wait_valid(n);
      chk("t3b_diff", diff, 32'h80000000);
      chk("t3b_ovf", ovf, 1);
      chk("t3b_bout", bout, 1);
      tick();

      // backpressure: 5-cycle stall once the first result is valid
      got0 = n_got; i = 0; lowc = 0; started = 1'b0; held = '0;
      for (int cyc = 0; cyc < 80 && (i < 8 || out_ready == 1'b0); cyc++) begin
         in_valid = (i < 8);
         in1 = i * 1000 + 7;
         in2 = i * 3;
         bin = i[0];
         if (!out_ready) begin
            lowc++;
            if (lowc == 5) out_ready = 1'b1;
         end
         if (!started && out_valid) begin
            out_ready = 1'b0;
            started = 1'b1;
            held = diff;
         end
         #1;
         if (!out_ready) begin
            chk("t4_in_ready_low", in_ready, 0);
            chk("t4_diff_held", diff, held);
            chk("t4_valid_held", out_valid, 1);
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) i++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("t4_stall_seen", started, 1);
      drain();
      chk("t4_count", n_got - got0, 8);

      // reset mid-flight
      put(32'd7, 32'd2, 1'b0);
      put(32'd100, 32'd1, 1'b0);
      put(32'd5, 32'd9, 1'b1);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("t5_no_stale", out_valid, 0);
         tick();
      end
      chk("t5_in_ready", in_ready, 1);
      put(32'd20, 32'd5, 1'b0);
      in_valid = 1'b0;
      wait_valid(n);
      chk("t5_latency", n + 1, 7);
      chk("t5_diff", diff, 32'd15);
      chk("t5_bout", bout, 0);
      tick();

      // random regression with random handshakes
      got0 = n_got;
      for (int k = 0; k < 3000; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in1 = $urandom;
         in2 = $urandom;
         bin = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0: in1 = 32'd0;
            1: in1 = 32'hFFFFFFFF;
            2: in2 = in1;
            3: in2 = 32'd0;
            default: ;
         endcase
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("t6_some_results", n_got - got0 > 1000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
